// File: rtl/wishbone_pkg.sv
// Shared constants and state encoding for the Wishbone burst master.
package wishbone_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_TIMEOUT = 2'd1;
    localparam logic [1:0] RSP_ERR     = 2'd2;
    localparam logic [1:0] RSP_BUSY    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_BURST,
        ST_RESP
    } state_t;

endpackage

// File: rtl/wb_wait_timer.sv
// Down-counting wait timer: load to MAX_WAIT, decrement while idle, expired at zero.
module wb_wait_timer #(
    parameter int MAX_WAIT  = 8,
    parameter int CNT_WIDTH = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_WIDTH'(MAX_WAIT);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/wishbone_burst_master.sv
// Wishbone B4 classic-cycle incrementing burst master with command/response handshakes.
//   state    | meaning
//   ST_IDLE  | ready for a command
//   ST_ARB   | waiting for another master to release the bus
//   ST_BURST | driving beats, one per ack
//   ST_RESP  | presenting the result until rsp_ready
module wishbone_burst_master
    import wishbone_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int SEL_WIDTH     = DATA_WIDTH / 8,
    parameter int MAX_PAYLOAD   = 8,
    parameter int MAX_WAIT      = 8,
    parameter int LEN_WIDTH     = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    output logic [ADDRESS_WIDTH-1:0]          adr_o,
    output logic [DATA_WIDTH-1:0]             dat_o,
    input  logic [DATA_WIDTH-1:0]             dat_i,
    output logic                              we_o,
    output logic [SEL_WIDTH-1:0]              sel_o,
    output logic                              stb_o,
    output logic                              cyc_o,
    output logic [2:0]                        cti_o,
    output logic [1:0]                        bte_o,
    input  logic                              ack_i,
    input  logic                              err_i,
    input  logic                              cyc_i,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]          cmd_address,
    input  logic [LEN_WIDTH-1:0]              cmd_length,
    input  logic [MAX_PAYLOAD*DATA_WIDTH-1:0] cmd_payload,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [1:0]                        rsp_status,
    output logic [LEN_WIDTH-1:0]              rsp_count,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] rsp_payload
);

    localparam int IDX_WIDTH = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    state_t state_q, state_d;

    logic [ADDRESS_WIDTH-1:0]                 addr_q;
    logic                                     write_q;
    logic [LEN_WIDTH-1:0]                     len_q;
    logic [IDX_WIDTH-1:0]                     beat_q;
    logic [LEN_WIDTH-1:0]                     rsp_count_q;
    logic [1:0]                               rsp_status_q;
    logic [MAX_PAYLOAD-1:0][DATA_WIDTH-1:0]   payload_q;
    logic [MAX_PAYLOAD-1:0][DATA_WIDTH-1:0]   rd_data_q;

    logic           accept, beat_done, set_status;
    logic [1:0]     status_d;
    logic           timer_load, timer_dec, timer_expired;
    logic           in_burst, is_last;
    logic [LEN_WIDTH-1:0] len_clamped;

    wb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (timer_load),
        .dec     (timer_dec),
        .expired (timer_expired)
    );

    assign len_clamped = (cmd_length > LEN_WIDTH'(MAX_PAYLOAD)) ? LEN_WIDTH'(MAX_PAYLOAD) : cmd_length;
    assign is_last     = ((rsp_count_q + LEN_WIDTH'(1)) == len_q);
    assign in_burst    = (state_q == ST_BURST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // err_i is tested before ack_i so a simultaneous error never counts the beat.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        beat_done  = 1'b0;
        set_status = 1'b0;
        status_d   = RSP_OK;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    if (cmd_length == '0) begin
                        state_d    = ST_RESP;
                        set_status = 1'b1;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_ARB: begin
                if (!cyc_i) begin
                    state_d    = ST_BURST;
                    timer_load = 1'b1;
                end else if (timer_expired) begin
                    state_d    = ST_RESP;
                    set_status = 1'b1;
                    status_d   = RSP_BUSY;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_BURST: begin
                if (err_i) begin
                    state_d    = ST_RESP;
                    set_status = 1'b1;
                    status_d   = RSP_ERR;
                end else if (ack_i) begin
                    beat_done  = 1'b1;
                    timer_load = 1'b1;
                    if (is_last) begin
                        state_d    = ST_RESP;
                        set_status = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d    = ST_RESP;
                    set_status = 1'b1;
                    status_d   = RSP_TIMEOUT;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            write_q      <= 1'b0;
            len_q        <= '0;
            beat_q       <= '0;
            rsp_count_q  <= '0;
            rsp_status_q <= RSP_OK;
            payload_q    <= '0;
            rd_data_q    <= '0;
        end else begin
            if (accept) begin
                addr_q      <= cmd_address;
                write_q     <= cmd_write;
                len_q       <= len_clamped;
                payload_q   <= cmd_payload;
                beat_q      <= '0;
                rsp_count_q <= '0;
                rd_data_q   <= '0;
            end
            if (beat_done) begin
                if (!write_q) begin
                    rd_data_q[beat_q] <= dat_i;
                end
                beat_q      <= beat_q + IDX_WIDTH'(1);
                rsp_count_q <= rsp_count_q + LEN_WIDTH'(1);
            end
            if (set_status) begin
                rsp_status_q <= status_d;
            end
        end
    end

    assign cyc_o = in_burst;
    assign stb_o = in_burst;
    assign we_o  = in_burst & write_q;
    assign sel_o = in_burst ? {SEL_WIDTH{1'b1}} : '0;
    assign adr_o = in_burst ? (addr_q + ADDRESS_WIDTH'(beat_q)) : '0;
    assign dat_o = (in_burst && write_q) ? payload_q[beat_q] : '0;
    assign cti_o = in_burst ? (is_last ? CTI_END : CTI_INCR) : CTI_CLASSIC;
    assign bte_o = BTE_LINEAR;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_status  = rsp_status_q;
    assign rsp_count   = rsp_count_q;
    assign rsp_payload = rd_data_q;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Directed and randomized checks of wishbone_burst_master against a beat-level reference model.
module tb_wishbone_burst_master;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MP = 8;
    localparam int MW = 8;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   dat_o;
    logic [DW-1:0]   dat_i;
    logic            we_o;
    logic [0:0]      sel_o;
    logic            stb_o, cyc_o;
    logic [2:0]      cti_o;
    logic [1:0]      bte_o;
    logic            ack_i, err_i, cyc_i;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_address;
    logic [LW-1:0]   cmd_length;
    logic [MP*DW-1:0] cmd_payload;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_status;
    logic [LW-1:0]   rsp_count;
    logic [MP*DW-1:0] rsp_payload;

    always #5 clk = ~clk;

    wishbone_burst_master dut (
        .clk_i(clk), .rst_i(rst_i),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .cti_o(cti_o), .bte_o(bte_o),
        .ack_i(ack_i), .err_i(err_i), .cyc_i(cyc_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_length(cmd_length), .cmd_payload(cmd_payload),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_count(rsp_count), .rsp_payload(rsp_payload)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] seed;

    int         stall_cfg [MP];
    bit         err_cfg   [MP];
    int         busy_cfg;
    logic [7:0] pay_cfg   [MP];

    logic [1:0]  e_status;
    int          e_count, e_busy;
    logic [63:0] e_payload;
    logic [26:0] e_beat[$];
    logic [26:0] o_beat[$];
    int          o_we_bad, o_sel_bad, o_overlap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ seed;
    endfunction

    task automatic clear_cfg();
        for (int k = 0; k < MP; k++) begin
            stall_cfg[k] = 0;
            err_cfg[k]   = 1'b0;
            pay_cfg[k]   = 8'($urandom);
        end
        busy_cfg = 0;
    endtask

    // Beat-level model: each beat occupies stall+1 strobe cycles, or MAX_WAIT+1 on timeout.
    task automatic build_model(input bit wr, input logic [15:0] a, input int len);
        int n;
        int cycles;
        logic [15:0] ak;
        n = (len > MP) ? MP : len;
        e_beat.delete();
        e_status = 2'd0; e_count = 0; e_payload = '0; e_busy = 0;
        if (n == 0) return;
        if (busy_cfg >= MW + 1) begin
            e_status = 2'd3;
            e_busy   = MW + 1;
            return;
        end
        e_busy = busy_cfg + 1;
        for (int k = 0; k < n; k++) begin
            ak     = a + 16'(k);
            cycles = (stall_cfg[k] >= MW + 1) ? MW + 1 : stall_cfg[k] + 1;
            for (int c = 0; c < cycles; c++)
                e_beat.push_back({ak, (k == n - 1) ? 3'b111 : 3'b010, wr ? pay_cfg[k] : 8'h00});
            e_busy += cycles;
            if (stall_cfg[k] >= MW + 1) begin e_status = 2'd1; return; end
            if (err_cfg[k]) begin e_status = 2'd2; return; end
            e_count++;
            if (!wr) e_payload[k*8 +: 8] = mem_byte(ak);
        end
    endtask

    task automatic run_cmd(input string name, input bit wr, input logic [15:0] a,
                           input logic [3:0] len, input int hold);
        int cyc, acks, scnt, busy, nmin;
        bit done, held;
        logic [63:0] pk;
        for (int k = 0; k < MP; k++) pk[k*8 +: 8] = pay_cfg[k];
        build_model(wr, a, int'(len));
        @(negedge clk);
        check({name, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_length = len; cmd_payload = pk;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_address = 16'($urandom);
        cmd_payload = {$urandom, $urandom};
        o_beat.delete(); o_we_bad = 0; o_sel_bad = 0; o_overlap = 0;
        cyc = 0; acks = 0; scnt = 0; busy = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                busy++;
                cyc_i = (cyc < busy_cfg);
                if (cyc_o && cyc_i) o_overlap++;
                if (stb_o) begin
                    o_beat.push_back({adr_o, cti_o, dat_o});
                    if (we_o !== wr) o_we_bad++;
                    if (sel_o !== 1'b1 || cyc_o !== 1'b1 || bte_o !== 2'b00) o_sel_bad++;
                    dat_i = mem_byte(adr_o);
                    if (acks >= MP) begin
                        ack_i = 1'b1; err_i = 1'b0;
                    end else if (scnt < stall_cfg[acks]) begin
                        ack_i = 1'b0; err_i = 1'b0; scnt++;
                    end else if (err_cfg[acks]) begin
                        ack_i = 1'b1; err_i = 1'b1;
                    end else begin
                        ack_i = 1'b1; err_i = 1'b0; acks++; scnt = 0;
                    end
                end else begin
                    ack_i = 1'b0; err_i = 1'b0; dat_i = 8'($urandom);
                end
                cyc++;
            end
        end
        ack_i = 1'b0; err_i = 1'b0; cyc_i = 1'b0;
        check({name, "_rsp_seen"}, 64'(done), 64'(1));
        check({name, "_status"}, 64'(rsp_status), 64'(e_status));
        check({name, "_count"}, 64'(rsp_count), 64'(e_count));
        check({name, "_payload"}, rsp_payload, e_payload);
        check({name, "_busy_cycles"}, 64'(busy), 64'(e_busy));
        check({name, "_stb_cycles"}, 64'(o_beat.size()), 64'(e_beat.size()));
        check({name, "_we_sel_overlap"}, 64'(o_we_bad + o_sel_bad + o_overlap), 64'(0));
        nmin = (o_beat.size() < e_beat.size()) ? o_beat.size() : e_beat.size();
        for (int i = 0; i < nmin; i++)
            check($sformatf("%s_beat%0d", name, i), 64'(o_beat[i]), 64'(e_beat[i]));
        held = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready) held = 1'b0;
        end
        check({name, "_rsp_held"}, 64'(held), 64'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_released"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    endtask

    initial begin
        seed = 8'($urandom);
        rst_i = 1'b1; ack_i = 1'b0; err_i = 1'b0; cyc_i = 1'b0; dat_i = '0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_length = '0;
        cmd_payload = '0; rsp_ready = 1'b0;
        clear_cfg();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        check("reset_handshake", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
        check("reset_bus", 64'({cyc_o, stb_o, we_o, sel_o, cti_o, bte_o, adr_o, dat_o}), 64'(0));
        check("reset_rsp", 64'({rsp_status, rsp_count}), 64'(0));
        check("reset_payload", rsp_payload, 64'(0));

        clear_cfg();
        run_cmd("read4_wrap", 1'b0, 16'h00FE, 4'd4, 2);

        clear_cfg(); stall_cfg[1] = 2;
        run_cmd("write3_stall", 1'b1, 16'h4000, 4'd3, 1);

        clear_cfg(); stall_cfg[0] = MW + 1;
        run_cmd("timeout", 1'b0, 16'h1230, 4'd4, 0);

        clear_cfg(); err_cfg[2] = 1'b1;
        run_cmd("err_beat2", 1'b0, 16'h8000, 4'd4, 1);

        clear_cfg(); busy_cfg = 20;
        run_cmd("bus_busy", 1'b1, 16'h0010, 4'd2, 0);

        clear_cfg();
        run_cmd("len0", 1'b1, 16'hABCD, 4'd0, 3);

        clear_cfg(); stall_cfg[7] = MW;
        run_cmd("clamp12", 1'b0, 16'hFFFC, 4'd12, 0);

        // Reset in the middle of a read after two acknowledged beats.
        clear_cfg();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'h2222; cmd_length = 4'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); ack_i = 1'b1; dat_i = 8'hA5;
        @(negedge clk); ack_i = 1'b1; dat_i = 8'h5A;
        @(negedge clk); ack_i = 1'b0;
        check("midrst_pre", 64'({stb_o, rsp_count}), 64'({1'b1, 4'd2}));
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("midrst_bus", 64'({cyc_o, stb_o, adr_o, cti_o}), 64'(0));
        check("midrst_handshake", 64'({cmd_ready, rsp_valid, rsp_status, rsp_count}), 64'({1'b1, 7'd0}));
        check("midrst_payload", rsp_payload, 64'(0));
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        clear_cfg();
        run_cmd("after_rst", 1'b1, 16'h0700, 4'd2, 4);

        for (int it = 0; it < 40; it++) begin
            clear_cfg();
            busy_cfg = ($urandom_range(0, 7) == 0) ? MW + 3 : $urandom_range(0, 3);
            for (int k = 0; k < MP; k++) begin
                stall_cfg[k] = ($urandom_range(0, 19) == 0) ? MW + 1 : $urandom_range(0, 3);
                err_cfg[k]   = ($urandom_range(0, 11) == 0);
            end
            run_cmd($sformatf("rand%0d", it), 1'($urandom), 16'($urandom),
                    4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_burst_master.md
# wishbone_burst_master

Parametrised Wishbone B4 classic-cycle burst master, the next generation of the badge's single-channel bus master. It accepts one command at a time over a valid/ready handshake and runs an incrementing burst of 1..MAX_PAYLOAD beats. It adds true STB/SEL driving, ERR handling, a bus-busy abort, and a response handshake. It sits between command sources (USB/SPI bridges, sequencers) and the shared Wishbone interconnect.

## Interface
- ADDRESS_WIDTH, 16, adr_o/cmd_address width
- DATA_WIDTH, 8, bus data width; multiple of 8
- SEL_WIDTH, DATA_WIDTH/8, byte-select lanes
- MAX_PAYLOAD, 8, max beats per burst, 1..64
- MAX_WAIT, 8, idle cycles tolerated per beat / per arbitration wait
- LEN_WIDTH, $clog2(MAX_PAYLOAD+1), cmd_length/rsp_count width
- clk_i  in  1  clock
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- adr_o  out  ADDRESS_WIDTH  beat address
- dat_o  out  DATA_WIDTH  write data
- dat_i  in  DATA_WIDTH  read data
- we_o  out  1  write enable
- sel_o  out  SEL_WIDTH  byte selects
- stb_o, cyc_o  out  1  strobe, cycle
- cti_o  out  3  cycle type; bte_o  out  2  burst type
- ack_i, err_i  in  1  slave acknowledge / error
- cyc_i  in  1  another master owns the bus
- cmd_valid  in  1; cmd_ready  out  1  command handshake
- cmd_write  in  1  1=write, 0=read
- cmd_address  in  ADDRESS_WIDTH  start address
- cmd_length  in  LEN_WIDTH  beat count
- cmd_payload  in  MAX_PAYLOAD*DATA_WIDTH  write data; beat k in lane k (LSB lane 0)
- rsp_valid  out  1; rsp_ready  in  1  response handshake
- rsp_status  out  2  0 OK, 1 TIMEOUT, 2 ERR, 3 BUSY
- rsp_count  out  LEN_WIDTH  beats acknowledged
- rsp_payload  out  MAX_PAYLOAD*DATA_WIDTH  read data, lane k = beat k

## Operation
- States: IDLE, ARB, BURST, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch address, write flag, payload, length; clear rsp_payload, rsp_count. Length 0 -> RESP, status OK, no bus cycle. Length > MAX_PAYLOAD clamps to MAX_PAYLOAD.
- ARB: cyc_i low -> BURST. cyc_i high MAX_WAIT+1 consecutive cycles -> RESP, BUSY.
- BURST: cyc_o=stb_o=1, sel_o all ones, we_o=write flag, bte_o=00, adr_o=base+beat mod 2^ADDRESS_WIDTH. cti_o=010 except the last beat, which is 111. dat_o = payload lane[beat] on writes, else 0.
- Beat completes on a rising edge with stb_o&ack_i. Reads capture dat_i into lane[beat]. rsp_count increments. Last beat -> RESP, OK.
- err_i with stb_o -> RESP, ERR. The erroring beat is not counted or captured. err_i wins over a simultaneous ack_i.
- Wait counter loads MAX_WAIT at each ARB/BURST entry and each completed beat. It decrements each cycle without ack/err. Reaching 0 with no ack -> RESP, TIMEOUT.
- RESP: rsp_valid=1, held until rsp_ready; then IDLE. cmd_ready=0 outside IDLE.
- ack_i/err_i ignored when stb_o=0.

## Timing
- Reset values: all bus outputs 0, cmd_ready 1 (IDLE), rsp_valid 0, rsp_status 0, rsp_count 0, rsp_payload 0.
- Accept at edge T -> ARB during T+1. With cyc_i low, cyc_o/stb_o high from T+2.
- Zero-wait slave: an N-beat burst occupies N cycles; rsp_valid in the cycle after the last ack.
- Bus outputs are combinational from registered state only; no path from ack_i to adr_o within a cycle.
- cyc_o drops the cycle after the terminating edge; no gap between beats.
- Reset mid-burst: cyc_o/stb_o low the next cycle, no response issued.
- Timeout: stb_o high for exactly MAX_WAIT+1 cycles without ack.

## Structure
- Package wishbone_pkg: CTI constants (000, 010, 111), BTE linear, rsp_status codes, state encoding.
- Sub-module wb_wait_timer: load/decrement/expired counter, reused for ARB and per-beat waits.

## Test plan
- Read, length 4 at 0x00FE, zero-wait slave -> adr 0x00FE,0x00FF,0x0100,0x0101; cti 010,010,010,111; status OK; count 4; payload lanes match.
- Write, length 3, slave stalls 2 cycles on beat 1 -> dat_o holds lane 1 during the stall; 5 bus cycles total; OK.
- Slave never acks, MAX_WAIT=8 -> stb_o high 9 cycles; status TIMEOUT; count 0.
- err_i with ack_i on beat 2 of 4 -> status ERR; count 2; lanes 2-3 read zero.
- cyc_i held high 20 cycles -> no cyc_o; status BUSY after 9 ARB cycles. Length 0 -> immediate OK with count 0.
- rst_i mid-burst, then rsp_ready held low -> outputs at reset values; a new command is accepted; rsp_valid held until rsp_ready.
